// File: rtl/vregfile_multiport.sv
// Vector-lane register file: NUMRDPORTS registered read ports, one
// byte-enabled write port, optional write-to-read bypass, and a clear
// sequencer that zeroes every register after reset before raising ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   rd_reg     packed read addresses, port p at [p*LOG2NUMREGS +: LOG2NUMREGS]
//   rd_en      per-port read enable
//   rd_data    packed registered read data, port p at [p*WIDTH +: WIDTH]
//   wr_reg     write address
//   wr_data    write data
//   wr_byteen  byte enables, bit b covers [8b+7:8b]
//   wr_we      write enable
//   ready      high once the file accepts reads and writes
module vregfile_multiport #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned NUMREGS        = 16,
  parameter int unsigned LOG2NUMREGS    = 4,
  parameter int unsigned NUMRDPORTS     = 2,
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUMRDPORTS*LOG2NUMREGS-1:0] rd_reg,
  input  logic [NUMRDPORTS-1:0]             rd_en,
  output logic [NUMRDPORTS*WIDTH-1:0]       rd_data,
  input  logic [LOG2NUMREGS-1:0]            wr_reg,
  input  logic [WIDTH-1:0]                  wr_data,
  input  logic [WIDTH/8-1:0]                wr_byteen,
  input  logic                              wr_we,
  output logic                              ready
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned AW     = LOG2NUMREGS;
  localparam logic [AW-1:0] LAST_REG = AW'(NUMREGS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0] regs [NUMREGS];

  logic             wr_in_range_c;
  logic             wr_ok_c;
  logic [WIDTH-1:0] wr_old_c;
  logic [WIDTH-1:0] wr_merged_c;
  logic [WIDTH-1:0] rd_val_c [NUMRDPORTS];

  // Replace the enabled bytes of old_v with those of new_v.
  function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0]  old_v,
                                                  input logic [WIDTH-1:0]  new_v,
                                                  input logic [NBYTES-1:0] be);
    logic [WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < NBYTES; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // State and clear-counter registers; ready tracks the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      ready     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready     <= (state_d == ST_RUN);
    end
  end

  // Next state: walk the counter through every register, then run.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == LAST_REG) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = RESET_STATE;
    endcase
  end

  // Write port decode; out-of-range addresses are dropped.
  always_comb begin
    wr_in_range_c = (32'(wr_reg) < NUMREGS);
    wr_ok_c       = (state_q == ST_RUN) && wr_we && wr_in_range_c;
    wr_old_c      = wr_in_range_c ? regs[wr_reg] : '0;
    wr_merged_c   = byte_merge(wr_old_c, wr_data, wr_byteen);
  end

  // Storage: cleared entry by entry in CLEAR, written in RUN; reset drops writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        regs[clr_cnt_q] <= '0;
      end else if (wr_ok_c) begin
        regs[wr_reg] <= wr_merged_c;
      end
    end
  end

  // Per-port read value, with optional same-cycle write forwarding.
  always_comb begin
    for (int p = 0; p < NUMRDPORTS; p++) begin
      rd_val_c[p] = '0;
      if (32'(rd_reg[p*AW +: AW]) < NUMREGS) begin
        rd_val_c[p] = regs[rd_reg[p*AW +: AW]];
        if ((BYPASS != 0) && wr_ok_c && (wr_reg == rd_reg[p*AW +: AW])) begin
          rd_val_c[p] = wr_merged_c;
        end
      end
    end
  end

  // Read data registers: hold when disabled and throughout CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (state_q == ST_RUN) begin
      for (int p = 0; p < NUMRDPORTS; p++) begin
        if (rd_en[p]) rd_data[p*WIDTH +: WIDTH] <= rd_val_c[p];
      end
    end
  end

endmodule

// File: tb/tb_vregfile_multiport.sv
// Bench for vregfile_multiport: three instances (defaults; BYPASS=0 with
// NUMREGS=12; CLEAR_ON_RESET=0) share one stimulus stream and are checked
// every cycle against an array-based reference model.
module tb_vregfile_multiport;

  localparam int unsigned W = 32;
  localparam int unsigned L = 4;
  localparam int unsigned P = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [P*L-1:0] rd_reg;
  logic [P-1:0]   rd_en;
  logic [L-1:0]   wr_reg;
  logic [W-1:0]   wr_data;
  logic [W/8-1:0] wr_byteen;
  logic           wr_we;
  logic [P*W-1:0] rd_a, rd_b, rd_c;
  logic           ready_a, ready_b, ready_c;

  always #5 clk = ~clk;

  vregfile_multiport dut_a (
    .clk(clk), .reset(reset), .rd_reg(rd_reg), .rd_en(rd_en), .rd_data(rd_a),
    .wr_reg(wr_reg), .wr_data(wr_data), .wr_byteen(wr_byteen), .wr_we(wr_we),
    .ready(ready_a));

  vregfile_multiport #(.NUMREGS(12), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_reg(rd_reg), .rd_en(rd_en), .rd_data(rd_b),
    .wr_reg(wr_reg), .wr_data(wr_data), .wr_byteen(wr_byteen), .wr_we(wr_we),
    .ready(ready_b));

  vregfile_multiport #(.CLEAR_ON_RESET(0)) dut_c (
    .clk(clk), .reset(reset), .rd_reg(rd_reg), .rd_en(rd_en), .rd_data(rd_c),
    .wr_reg(wr_reg), .wr_data(wr_data), .wr_byteen(wr_byteen), .wr_we(wr_we),
    .ready(ready_c));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model for dut_a (index 0) and dut_b (index 1).
  int          m_n   [2] = '{16, 12};
  bit          m_byp [2] = '{1'b1, 1'b0};
  logic [31:0] m_mem [2][16];
  int          m_clr [2] = '{0, 0};
  logic [31:0] m_rd  [2][2];
  logic        m_rdy [3];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (be[b]) m = m | (32'hFF << (8 * b));
    return (o & ~m) | (d & m);
  endfunction

  // Advance the model over the upcoming clock edge using the current inputs.
  task automatic model_step();
    int          a;
    logic [31:0] v;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_clr[d]    = m_n[d];
        m_rd[d][0]  = '0;
        m_rd[d][1]  = '0;
        m_rdy[d]    = 1'b0;
      end else if (m_clr[d] > 0) begin
        m_mem[d][m_n[d] - m_clr[d]] = '0;
        m_clr[d]--;
        m_rdy[d] = (m_clr[d] == 0);
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (rd_en[p]) begin
            a = int'(rd_reg[p*L +: L]);
            if (a >= m_n[d]) v = '0;
            else begin
              v = m_mem[d][a];
              if (m_byp[d] && wr_we && int'(wr_reg) == a) v = merge(v, wr_data, wr_byteen);
            end
            m_rd[d][p] = v;
          end
        end
        if (wr_we && int'(wr_reg) < m_n[d])
          m_mem[d][wr_reg] = merge(m_mem[d][wr_reg], wr_data, wr_byteen);
        m_rdy[d] = 1'b1;
      end
    end
    m_rdy[2] = !reset;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("ready_a", 64'(ready_a), 64'(m_rdy[0]));
    chk("ready_b", 64'(ready_b), 64'(m_rdy[1]));
    chk("ready_c", 64'(ready_c), 64'(m_rdy[2]));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd_a%0d", p), 64'(rd_a[p*W +: W]), 64'(m_rd[0][p]));
      chk($sformatf("rd_b%0d", p), 64'(rd_b[p*W +: W]), 64'(m_rd[1][p]));
    end
  endtask

  task automatic idle();
    reset     = 1'b0;
    rd_reg    = '0;
    rd_en     = '0;
    wr_reg    = '0;
    wr_data   = '0;
    wr_byteen = '0;
    wr_we     = 1'b0;
  endtask

  task automatic wr(input int r, input logic [31:0] d, input logic [3:0] be);
    idle();
    wr_we = 1'b1; wr_reg = L'(r); wr_data = d; wr_byteen = be;
    cycle();
    idle();
  endtask

  task automatic rd(input int r0, input int r1, input logic [1:0] en);
    idle();
    rd_reg = {L'(r1), L'(r0)}; rd_en = en;
    cycle();
    idle();
  endtask

  // Count edges after reset release until ready rises (bounded).
  task automatic wait_ready(input string tag);
    int n, nb;
    n = 0; nb = -1;
    idle();
    while (!ready_a && n < 40) begin
      cycle();
      n++;
      if (ready_b && nb < 0) nb = n;
    end
    chk({tag, "_a"}, 64'(n), 64'(16));
    chk({tag, "_b"}, 64'(nb), 64'(12));
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) cycle();
    wait_ready("clr_len");

    for (int a = 0; a < 16; a++) begin
      rd(a, a, 2'b11);
      chk("clr_rd", 64'(rd_a), 64'(0));
    end

    wr(5, 32'hAABBCCDD, 4'b1111);
    wr(5, 32'h11223344, 4'b0101);
    rd(5, 5, 2'b01);
    chk("byteen", 64'(rd_a[31:0]), 64'(32'hAA22CC44));

    wr(3, 32'h12345678, 4'b1111);
    wr(4, 32'h0, 4'b1111);
    idle();
    wr_we = 1'b1; wr_reg = 4'd3; wr_data = 32'hFFFFFFFF; wr_byteen = 4'b0011;
    rd_reg = {4'd4, 4'd3}; rd_en = 2'b11;
    cycle();
    chk("byp_p0_a", 64'(rd_a[31:0]), 64'(32'h1234FFFF));
    chk("byp_p1_a", 64'(rd_a[63:32]), 64'(0));
    chk("byp_p0_b", 64'(rd_b[31:0]), 64'(32'h12345678));

    wr(7, 32'hCAFEF00D, 4'b1111);
    rd(0, 7, 2'b10);
    repeat (5) wr(7, 32'h0, 4'b1111);
    chk("hold", 64'(rd_a[63:32]), 64'(32'hCAFEF00D));

    // Reset in the middle of the clear sequence.
    idle(); reset = 1'b1; cycle();
    idle(); repeat (9) cycle();
    reset = 1'b1; cycle();
    wait_ready("clr_mid");

    // Reset in RUN with a coincident write.
    wr(2, 32'h1, 4'b1111);
    rd(2, 2, 2'b11);
    chk("r2_set", 64'(rd_a[31:0]), 64'(1));
    idle();
    reset = 1'b1; wr_we = 1'b1; wr_reg = 4'd2; wr_data = 32'h5A5A5A5A; wr_byteen = 4'hF;
    cycle();
    chk("rst_rd", 64'(rd_a), 64'(0));
    chk("rst_ready", 64'(ready_a), 64'(0));
    wait_ready("clr_run");
    rd(2, 2, 2'b11);
    chk("r2_cleared", 64'(rd_a[31:0]), 64'(0));
    chk("rst_drop_c", 64'(rd_c[31:0]), 64'(1));

    // Out-of-range on the 12-entry instance.
    wr(13, 32'h5, 4'b1111);
    rd(13, 13, 2'b11);
    chk("oor_b", 64'(rd_b), 64'(0));
    for (int a = 0; a < 12; a++) rd(a, 11 - a, 2'b11);

    // Random traffic with occasional resets and biased collisions.
    repeat (600) begin
      reset     = ($urandom_range(99) == 0);
      rd_reg    = 8'($urandom);
      rd_en     = 2'($urandom);
      wr_reg    = 4'($urandom);
      wr_data   = $urandom;
      wr_byteen = 4'($urandom);
      wr_we     = 1'($urandom);
      if ($urandom_range(3) == 0) rd_reg[L-1:0] = wr_reg;
      if ($urandom_range(3) == 0) rd_reg[2*L-1:L] = rd_reg[L-1:0];
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
